neural_simd_ctrl: RTL and testbench

- Job sequencer for the 4-lane neural SIMD datapath: streams operand word pairs (frame t, frame t+1) into the SIMD unit and applies a per-job 32-bit lane mask.
- The SIMD cores have no stall input, so the block tracks results through a fixed-latency valid pipe and buffers them in an output FIFO.
- Issue is throttled by credits so a result is never dropped.
- Sits between the pixel fetch stream and the result writeback stream; SIMD operand and result buses connect straight to the SIMD instance.

---
 rtl/neural_pkg.sv | 14 +
 rtl/neural_simd_ctrl_if.sv | 49 ++++
 rtl/neural_res_fifo.sv | 53 +++++
 rtl/neural_simd_ctrl.sv | 140 ++++++++++++++
 tb/tb_neural_simd_ctrl.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/neural_pkg.sv
// Shared types and lane geometry for the neural SIMD job sequencer.
package neural_pkg;

  localparam int unsigned LANES  = 4;
  localparam int unsigned LANE_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_e;

endpackage

// File: rtl/neural_simd_ctrl_if.sv
// Config, fetch, SIMD and writeback buses of the neural SIMD job sequencer.
// The perf counter outputs exist only when NEURAL_SIMD_CTRL_PERF_EN is defined.
interface neural_simd_ctrl_if #(
  parameter int unsigned LEN_W = 16
);

  logic [31:0]      cfg_mask;
  logic [LEN_W-1:0] cfg_len;
  logic             start;
  logic             busy;
  logic             done;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_rs1;
  logic [31:0]      in_rs2;
  logic [31:0]      simd_rs1;
  logic [31:0]      simd_rs2;
  logic [31:0]      simd_mask;
  logic [31:0]      simd_rd;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic             out_last;
`ifdef NEURAL_SIMD_CTRL_PERF_EN
  logic [31:0]      perf_stall_in;
  logic [31:0]      perf_stall_out;
`endif

  // The sequencer itself.
  modport slave (
    input  cfg_mask, cfg_len, start, in_valid, in_rs1, in_rs2, simd_rd, out_ready,
    output busy, done, in_ready, simd_rs1, simd_rs2, simd_mask, out_valid, out_data,
           out_last
`ifdef NEURAL_SIMD_CTRL_PERF_EN
    , output perf_stall_in, perf_stall_out
`endif
  );

  // Everything around it: job control, fetch, SIMD core and writeback.
  modport master (
    output cfg_mask, cfg_len, start, in_valid, in_rs1, in_rs2, simd_rd, out_ready,
    input  busy, done, in_ready, simd_rs1, simd_rs2, simd_mask, out_valid, out_data,
           out_last
`ifdef NEURAL_SIMD_CTRL_PERF_EN
    , input perf_stall_in, perf_stall_out
`endif
  );

endinterface

// File: rtl/neural_res_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count; DEPTH must be a power of two.
module neural_res_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [DATA_W-1:0]        push_data_i,
  input  logic                     pop_i,
  output logic                     valid_o,
  output logic [DATA_W-1:0]        data_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_q, rd_q;
  logic [CW-1:0]     cnt_q;
  logic              empty, full, do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == FULL_CNT);
  assign do_pop  = pop_i && !empty;
  // A pop frees the slot in the same edge, so a full FIFO may still accept.
  assign do_push = push_i && (!full || do_pop);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // NOTE: storage is not reset; the pointers define validity and the head is masked when empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= push_data_i;
  end

  assign valid_o = !empty;
  assign data_o  = empty ? '0 : mem_q[rd_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/neural_simd_ctrl.sv
// Job sequencer for the 4-lane neural SIMD datapath: credit-throttled operand issue, fixed-latency
// result tracking and FWFT result buffering. NEURAL_SIMD_CTRL_PERF_EN adds saturating stall counters.
module neural_simd_ctrl
  import neural_pkg::*;
#(
  parameter int unsigned CORE_LAT   = 2,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned LEN_W      = 16
) (
  input logic               clk,
  input logic               rst,
  neural_simd_ctrl_if.slave bus
);

  localparam int unsigned DATA_W  = LANES * LANE_W;
  localparam int unsigned CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] CREDITS = (CW + 1)'(FIFO_DEPTH);

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  len_q, issued_q, popped_q;
  logic [DATA_W-1:0] mask_q, rs1_q, rs2_q;
  logic [CORE_LAT:0] vld_q;
  logic [CW-1:0]     inflight_q, fifo_cnt;
  logic [CW:0]       credit_used;
  logic [DATA_W-1:0] out_data;
  logic              accept, fire, capture, pop;
  logic              in_ready, out_valid, out_last, busy, done;

  assign accept      = (state_q == IDLE) && bus.start;
  assign credit_used = {1'b0, inflight_q} + {1'b0, fifo_cnt};
  // Credits count everything issued but not yet popped, so the core can never overrun the FIFO.
  assign in_ready    = (state_q == RUN) && (issued_q < len_q) && (credit_used < CREDITS);
  assign fire        = bus.in_valid && in_ready;
  assign capture     = vld_q[CORE_LAT];
  assign pop         = out_valid && bus.out_ready;
  assign out_last    = out_valid && (popped_q == len_q - LEN_W'(1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: state_d gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = (bus.cfg_len != '0) ? RUN : DONE;
      RUN:     if (fire && (issued_q + LEN_W'(1) == len_q)) state_d = DRAIN;
      DRAIN:   if (pop && out_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state_q)
      RUN, DRAIN: busy = 1'b1;
      DONE:       done = 1'b1;
      default:    ;
    endcase
  end

  // vld_q[0] marks operands sitting on simd_rs*; vld_q[CORE_LAT] marks their result on simd_rd.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q      <= '0;
      mask_q     <= '0;
      issued_q   <= '0;
      popped_q   <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      vld_q      <= '0;
      inflight_q <= '0;
    end else begin
      if (accept && (bus.cfg_len != '0)) begin
        len_q  <= bus.cfg_len;
        mask_q <= bus.cfg_mask;
      end
      if (accept) begin
        issued_q <= '0;
        popped_q <= '0;
      end else begin
        if (fire) issued_q <= issued_q + LEN_W'(1);
        if (pop)  popped_q <= popped_q + LEN_W'(1);
      end
      if (fire) begin
        rs1_q <= bus.in_rs1;
        rs2_q <= bus.in_rs2;
      end
      vld_q      <= {vld_q[CORE_LAT-1:0], fire};
      inflight_q <= inflight_q + CW'(fire) - CW'(capture);
    end
  end

  neural_res_fifo #(
    .DATA_W(DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_res_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (capture),
    .push_data_i(bus.simd_rd),
    .pop_i      (bus.out_ready),
    .valid_o    (out_valid),
    .data_o     (out_data),
    .count_o    (fifo_cnt)
  );

  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.in_ready  = in_ready;
  assign bus.simd_rs1  = rs1_q;
  assign bus.simd_rs2  = rs2_q;
  assign bus.simd_mask = mask_q;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data;
  assign bus.out_last  = out_last;

`ifdef NEURAL_SIMD_CTRL_PERF_EN
  logic [31:0] stall_in_q, stall_out_q;

  always_ff @(posedge clk) begin
    if (rst || accept) begin
      stall_in_q  <= '0;
      stall_out_q <= '0;
    end else begin
      if ((state_q == RUN) && bus.in_valid && !in_ready && (stall_in_q != '1))
        stall_in_q <= stall_in_q + 32'd1;
      if (out_valid && !bus.out_ready && (stall_out_q != '1))
        stall_out_q <= stall_out_q + 32'd1;
    end
  end

  assign bus.perf_stall_in  = stall_in_q;
  assign bus.perf_stall_out = stall_out_q;
`endif

endmodule

// File: tb/tb_neural_simd_ctrl.sv
// Self-checking bench for neural_simd_ctrl: behavioural SIMD core, scoreboard queue and job table.
module tb_neural_simd_ctrl;
  import neural_pkg::*;

  localparam int CORE_LAT   = 2;
  localparam int FIFO_DEPTH = 4;
  localparam int LEN_W      = 16;
  localparam int M_LO  = 0;
  localparam int M_HI  = 1;
  localparam int M_TOG = 2;
  localparam int M_RND = 3;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } sb_t;

  typedef struct {
    int          len;
    logic [31:0] mask;
    int          rdy_mode;
    int          iv_mode;
    int          exp_words;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  neural_simd_ctrl_if #(.LEN_W(LEN_W)) bus ();

  neural_simd_ctrl #(
    .CORE_LAT  (CORE_LAT),
    .FIFO_DEPTH(FIFO_DEPTH),
    .LEN_W     (LEN_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int          n_checks = 0;
  int          n_err    = 0;
  int          cyc      = 0;
  int          rdy_mode = M_LO;
  int          iv_mode  = M_LO;
  sb_t         sb_q[$];
  logic [31:0] exp_mask = '0;
  int          job_len = 0, job_fires = 0, job_pops = 0, max_outst = 0, done_cnt = 0;
  int          start_edge = 0, first_fire_edge = -1, first_ov_edge = -1;
  int          last_pop_edge = -1, done_edge = -1;
  bit          seen_in_ready = 1'b0, seen_out_valid = 1'b0;
  logic [31:0] core_q [CORE_LAT];

  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] m);
    logic [31:0] r;
    logic [7:0]  x, y;
    r = '0;
    for (int i = 0; i < LANES; i++) begin
      x = a[i*LANE_W +: LANE_W];
      y = b[i*LANE_W +: LANE_W];
      r[i*LANE_W +: LANE_W] = (x > y) ? x - y : y - x;
    end
    return r & m;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural SIMD core: result appears CORE_LAT edges after the operands change.
  always @(posedge clk) begin
    core_q[0] <= model(bus.simd_rs1, bus.simd_rs2, bus.simd_mask);
    for (int i = 1; i < CORE_LAT; i++) core_q[i] <= core_q[i-1];
  end
  assign bus.simd_rd = core_q[CORE_LAT-1];

  always @(posedge clk) cyc++;

  // Stimulus driver for operands, in_valid and out_ready.
  always @(posedge clk) begin
    #2;
    bus.in_rs1 = $urandom;
    bus.in_rs2 = $urandom;
    case (iv_mode)
      M_LO:    bus.in_valid = 1'b0;
      M_HI:    bus.in_valid = 1'b1;
      default: bus.in_valid = 1'($urandom_range(0, 1));
    endcase
    case (rdy_mode)
      M_LO:    bus.out_ready = 1'b0;
      M_HI:    bus.out_ready = 1'b1;
      M_TOG:   bus.out_ready = (bus.out_ready === 1'b1) ? 1'b0 : 1'b1;
      default: bus.out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: handshakes seen here complete at the next rising edge (cyc + 1).
  always @(negedge clk) begin
    sb_t e;
    if (!rst) begin
      if (bus.done === 1'b1) begin
        done_cnt++;
        done_edge = cyc;
      end
      if (bus.in_ready === 1'b1) seen_in_ready = 1'b1;
      if (bus.out_valid === 1'b1) begin
        seen_out_valid = 1'b1;
        if (first_ov_edge < 0) first_ov_edge = cyc;
      end
      if (job_fires - job_pops > max_outst) max_outst = job_fires - job_pops;
      if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin
        e.data = model(bus.in_rs1, bus.in_rs2, exp_mask);
        e.last = (job_fires == job_len - 1);
        sb_q.push_back(e);
        if (job_fires == 0) first_fire_edge = cyc + 1;
        job_fires++;
      end
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        if (sb_q.size() == 0) begin
          check("pop_without_fire", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("out_data", bus.out_data, e.data);
          check("out_last", 32'(bus.out_last), 32'(e.last));
        end
        if (bus.out_last === 1'b1) last_pop_edge = cyc + 1;
        job_pops++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input int len, input logic [31:0] mask);
    bus.cfg_len     = LEN_W'(len);
    bus.cfg_mask    = mask;
    bus.start       = 1'b1;
    job_len         = len;
    exp_mask        = mask;
    job_fires       = 0;
    job_pops        = 0;
    max_outst       = 0;
    done_cnt        = 0;
    first_fire_edge = -1;
    first_ov_edge   = -1;
    last_pop_edge   = -1;
    done_edge       = -1;
    seen_in_ready   = 1'b0;
    seen_out_valid  = 1'b0;
    start_edge      = cyc + 1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (done_cnt == 0 && n < budget) begin
      tick();
      n++;
    end
    if (done_cnt == 0) begin
      check({name, "_done_timeout"}, 32'd0, 32'd1);
    end else begin
      check({name, "_busy_low_after_done"}, 32'(bus.busy), 32'd0);
      check({name, "_done_single_cycle"}, 32'(bus.done), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t vecs [5];
    vecs[0] = '{5,  32'hFFFF_FFFF, M_HI,  M_HI,  5};
    vecs[1] = '{12, 32'h00FF_00FF, M_TOG, M_HI,  12};
    vecs[2] = '{9,  32'hF0F0_F0F0, M_RND, M_RND, 9};
    vecs[3] = '{1,  32'h1234_5678, M_HI,  M_HI,  1};
    vecs[4] = '{16, 32'h0000_FFFF, M_RND, M_HI,  16};

    bus.start    = 1'b0;
    bus.cfg_len  = '0;
    bus.cfg_mask = '0;
    rst = 1'b1;
    repeat (3) tick();
    check("rst_busy",      32'(bus.busy),      32'd0);
    check("rst_done",      32'(bus.done),      32'd0);
    check("rst_in_ready",  32'(bus.in_ready),  32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_last",  32'(bus.out_last),  32'd0);
    check("rst_simd_rs1",  bus.simd_rs1,       32'd0);
    check("rst_simd_rs2",  bus.simd_rs2,       32'd0);
    check("rst_simd_mask", bus.simd_mask,      32'd0);
    check("rst_out_data",  bus.out_data,       32'd0);
    rst = 1'b0;
    tick();

    // Basic three-word job with free-flowing output.
    rdy_mode = M_HI;
    iv_mode  = M_HI;
    start_job(3, 32'hFFFF_FFFF);
    wait_done("basic", 100);
    check("basic_words", 32'(job_pops), 32'd3);
    check("basic_first_valid_latency", 32'(first_ov_edge - first_fire_edge), 32'(CORE_LAT + 1));
    check("basic_done_after_last_pop", 32'(done_edge - last_pop_edge), 32'd0);

    // Zero-length job goes straight to DONE.
    start_job(0, 32'hA5A5_A5A5);
    wait_done("zero", 20);
    check("zero_done_latency", 32'(done_edge - start_edge), 32'd0);
    check("zero_no_in_ready",  32'(seen_in_ready),  32'd0);
    check("zero_no_out_valid", 32'(seen_out_valid), 32'd0);

    // Backpressure: credits stop issue at FIFO_DEPTH.
    rdy_mode = M_LO;
    iv_mode  = M_HI;
    start_job(10, 32'h0F0F_0F0F);
    repeat (20) tick();
    check("bp_fires_stalled", 32'(job_fires), 32'(FIFO_DEPTH));
    check("bp_in_ready_low",  32'(bus.in_ready), 32'd0);
    rdy_mode = M_HI;
    wait_done("bp", 200);
    check("bp_words",    32'(job_pops), 32'd10);
    check("bp_sb_empty", 32'(sb_q.size()), 32'd0);

    // Job table: toggled, random and steady output readiness.
    for (int v = 0; v < 5; v++) begin
      rdy_mode = vecs[v].rdy_mode;
      iv_mode  = vecs[v].iv_mode;
      start_job(vecs[v].len, vecs[v].mask);
      wait_done($sformatf("vec%0d", v), 600);
      check($sformatf("vec%0d_words", v), 32'(job_pops), 32'(vecs[v].exp_words));
      check($sformatf("vec%0d_sb_empty", v), 32'(sb_q.size()), 32'd0);
      check($sformatf("vec%0d_credit_bound", v), 32'(max_outst <= FIFO_DEPTH), 32'd1);
    end

    // Reset during DRAIN with two words buffered.
    rdy_mode = M_LO;
    iv_mode  = M_HI;
    start_job(2, 32'hCCCC_3333);
    repeat (8) tick();
    check("mid_rst_pre_busy",      32'(bus.busy),      32'd1);
    check("mid_rst_pre_out_valid", 32'(bus.out_valid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb_q.delete();
    done_cnt = 0;
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_busy",      32'(bus.busy),      32'd0);
    repeat (4) tick();
    check("mid_rst_no_done", 32'(done_cnt), 32'd0);
    rdy_mode = M_HI;
    start_job(1, 32'h0000_0F0F);
    wait_done("after_rst", 50);
    check("after_rst_words", 32'(job_pops), 32'd1);

    // Start pulses while busy are ignored and do not disturb the mask.
    start_job(6, 32'hFF00_FF00);
    repeat (2) tick();
    bus.cfg_mask = 32'h00FF_00FF;
    bus.cfg_len  = LEN_W'(2);
    bus.start    = 1'b1;
    tick();
    bus.start = 1'b0;
    check("mask_hold_mid_job", bus.simd_mask, 32'hFF00_FF00);
    wait_done("mask", 100);
    check("mask_words", 32'(job_pops), 32'd6);
    check("mask_hold_after_job", bus.simd_mask, 32'hFF00_FF00);
    start_job(1, 32'h1234_5678);
    check("mask_new_job", bus.simd_mask, 32'h1234_5678);
    wait_done("mask_new", 50);
    check("mask_new_words", 32'(job_pops), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
